// File: rtl/jtsdram_bank_chk_if.sv
// SDRAM arbiter slot bus between the bank checker (master) and one arbiter port (slave).
interface jtsdram_bank_chk_if #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] din;
    logic          ack;
    logic          rdy;
    logic [DW-1:0] data_read;

    modport master (
        output addr, rd, wr, din,
        input  ack, rdy, data_read
    );

    modport slave (
        input  addr, rd, wr, din,
        output ack, rdy, data_read
    );
endinterface

// File: rtl/jtsdram_bank_chk.sv
// SDRAM bank tester: optional pattern fill of the whole range, then read-back compare,
// with requests paced by LVBL so video refresh keeps its bandwidth.
module jtsdram_bank_chk #(
    parameter int unsigned AW   = 22,
    parameter int unsigned DW   = 32,
    parameter int unsigned ERRW = 16,
    parameter int unsigned MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                LVBL,
    input  logic                start,
    input  logic                wr_en,
    input  logic [15:0]         seed,
    jtsdram_bank_chk_if.master  bus,
    output logic                busy,
    output logic                bad,
    output logic                done,
    output logic [ERRW-1:0]     err_cnt,
    output logic [AW-1:0]       first_bad
);

    localparam int unsigned NREP = DW / 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 16-bit pattern word for an address, replicated across the data bus
    function automatic logic [DW-1:0] pat(input logic [15:0] s, input logic [AW-1:0] a);
        logic [15:0] p;
        p = (MODE == 0) ? s : (s ^ 16'(a));
        return {NREP{p}};
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            busy_q, busy_d;
    logic            bad_q, bad_d;
    logic            done_q, done_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [AW-1:0]   first_bad_q, first_bad_d;
    logic            pending_q, pending_d;
    logic            xfer_q, xfer_d;
    logic [15:0]     seed_q, seed_d;

    logic issue, raise, req_hit, rdy_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            bad_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            first_bad_q <= '0;
            pending_q   <= 1'b0;
            xfer_q      <= 1'b0;
            seed_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            bad_q       <= bad_d;
            done_q      <= done_d;
            err_q       <= err_d;
            first_bad_q <= first_bad_d;
            pending_q   <= pending_d;
            xfer_q      <= xfer_d;
            seed_q      <= seed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        din_d       = din_q;
        busy_d      = busy_q;
        bad_d       = bad_q;
        done_d      = done_q;
        err_d       = err_q;
        first_bad_d = first_bad_q;
        pending_d   = pending_q;
        xfer_d      = xfer_q;
        seed_d      = seed_q;
        issue       = 1'b0;
        raise       = 1'b0;
        req_hit     = 1'b0;
        rdy_hit     = 1'b0;

        if (start) begin
            state_d     = wr_en ? S_WRITE : S_READ;
            addr_d      = '0;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            busy_d      = 1'b1;
            bad_d       = 1'b0;
            done_d      = 1'b0;
            err_d       = '0;
            first_bad_d = '0;
            pending_d   = 1'b0;
            xfer_d      = 1'b0;
            seed_d      = seed;
            issue       = 1'b1;
        end else if (state_q == S_WRITE || state_q == S_READ) begin
            // a transfer counts as outstanding from the cycle its ack is seen
            req_hit = (rd_q | wr_q) & bus.ack;
            rdy_hit = bus.rdy & (xfer_q | req_hit);
            if (req_hit) begin
                rd_d   = 1'b0;
                wr_d   = 1'b0;
                xfer_d = 1'b1;
            end
            if (rdy_hit) begin
                xfer_d = 1'b0;
                if (state_q == S_READ && bus.data_read != pat(seed_q, addr_q)) begin
                    bad_d = 1'b1;
                    if (err_q != '1) err_d = err_q + ERRW'(1);
                    if (err_q == '0) first_bad_d = addr_q;
                end
                if (addr_q != '1) begin
                    addr_d = addr_q + AW'(1);
                    issue  = 1'b1;
                end else if (state_q == S_WRITE) begin
                    addr_d  = '0;
                    state_d = S_READ;
                    issue   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else if (pending_q && LVBL) begin
                pending_d = 1'b0;
                raise     = 1'b1;
            end
        end

        if (issue) begin
            if (LVBL) raise = 1'b1;
            else      pending_d = 1'b1;
        end

        if (raise) begin
            if (state_d == S_WRITE) begin
                wr_d  = 1'b1;
                din_d = pat(seed_d, addr_d);
            end else begin
                rd_d = 1'b1;
            end
        end
    end

    assign bus.addr  = addr_q;
    assign bus.rd    = rd_q;
    assign bus.wr    = wr_q;
    assign bus.din   = din_q;
    assign busy      = busy_q;
    assign bad       = bad_q;
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign first_bad = first_bad_q;

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Directed bench for jtsdram_bank_chk: a slot model with echo memory checks every
// request against a queue of expected transfers, plus end-of-run status checks.
module tb_jtsdram_bank_chk;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned ERRW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            LVBL;
    logic            start;
    logic            wr_en;
    logic [15:0]     seed;
    logic            busy, bad, done;
    logic [ERRW-1:0] err_cnt;
    logic [AW-1:0]   first_bad;

    jtsdram_bank_chk_if #(.AW(AW), .DW(DW)) bus ();

    jtsdram_bank_chk #(.AW(AW), .DW(DW), .ERRW(ERRW), .MODE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .LVBL      (LVBL),
        .start     (start),
        .wr_en     (wr_en),
        .seed      (seed),
        .bus       (bus),
        .busy      (busy),
        .bad       (bad),
        .done      (done),
        .err_cnt   (err_cnt),
        .first_bad (first_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_t;

    sb_t           exp_q[$];
    logic [DW-1:0] mem [16];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    int            n_rd     = 0;
    int            n_wr     = 0;
    int            ph       = 0;
    bit            combined = 1'b0;
    bit            zero_data = 1'b0;
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] c1 = 4'd9;
    logic [AW-1:0] c2 = 4'd12;
    logic [AW-1:0] cap_a = '0;
    logic [DW-1:0] din_at3 = '0;
    logic          start_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [15:0] s, input logic [AW-1:0] a);
        logic [15:0] p;
        p = s ^ {12'd0, a};
        return {p, p};
    endfunction

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = zero_data ? '0 : mem[a];
        if (corrupt_en && (a == c1 || a == c2)) v = v ^ 32'h0000_0100;
        return v;
    endfunction

    // pop the expected transfer and compare it with the request the DUT presents
    task automatic accept();
        sb_t e;
        check("one_hot", 64'(bus.rd & bus.wr), 64'd0);
        if (exp_q.size() == 0) begin
            check("sb_extra_req", 64'({bus.rd, bus.wr}), 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", 64'(bus.wr), 64'(e.is_wr));
            check("sb_addr", 64'(bus.addr), 64'(e.a));
            if (e.is_wr) check("sb_din", 64'(bus.din), 64'(e.d));
        end
        if (bus.wr) begin
            mem[bus.addr] = bus.din;
            n_wr++;
            if (bus.addr == 4'd3) din_at3 = bus.din;
        end else begin
            n_rd++;
        end
    endtask

    always @(posedge clk) start_seen <= start;

    // arbiter slot model: ack then rdy on the following cycle, or both together
    always @(negedge clk) begin
        if (start_seen || rst) begin
            ph      = 0;
            bus.ack = 1'b0;
            bus.rdy = 1'b0;
        end
        if (combined) begin
            if (bus.rd || bus.wr) begin
                bus.ack = 1'b1;
                bus.rdy = 1'b1;
                accept();
                bus.data_read = rdata(bus.addr);
            end else begin
                bus.ack = 1'b0;
                bus.rdy = 1'b0;
            end
        end else begin
            case (ph)
                0: begin
                    bus.rdy = 1'b0;
                    if (bus.rd || bus.wr) begin
                        bus.ack = 1'b1;
                        cap_a   = bus.addr;
                        accept();
                        ph = 1;
                    end
                end
                1: begin
                    bus.ack       = 1'b0;
                    bus.rdy       = 1'b1;
                    bus.data_read = rdata(cap_a);
                    ph = 2;
                end
                default: begin
                    bus.rdy = 1'b0;
                    ph = 0;
                end
            endcase
        end
    end

    task automatic start_run(input logic w, input logic [15:0] s);
        exp_q.delete();
        if (w) for (int a = 0; a < 16; a++) exp_q.push_back('{1'b1, AW'(a), pat(s, AW'(a))});
        for (int a = 0; a < 16; a++) exp_q.push_back('{1'b0, AW'(a), '0});
        @(negedge clk);
        #1;
        seed  = s;
        wr_en = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_rd  = 0;
        n_wr  = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int viol;
        rst   = 1'b1;
        LVBL  = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        seed  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_req", 64'({bus.rd, bus.wr}), 64'd0);
        check("rst_din", 64'(bus.din), 64'd0);
        check("rst_flags", 64'({busy, bad, done}), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_first_bad", 64'(first_bad), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // full write + read, clean echo memory
        start_run(1'b1, 16'hA5A5);
        wait_done("A");
        check("A_bad", 64'(bad), 64'd0);
        check("A_err", 64'(err_cnt), 64'd0);
        check("A_nwr", 64'(n_wr), 64'd16);
        check("A_nrd", 64'(n_rd), 64'd16);
        check("A_din3", 64'(din_at3), 64'h0000_0000_A5A6_A5A6);
        repeat (5) @(negedge clk);
        #1;
        check("A_done_hold", 64'(done), 64'd1);

        // corrupted reads at addr 9 and 12
        corrupt_en = 1'b1;
        c1 = 4'd9;
        c2 = 4'd12;
        start_run(1'b1, 16'hA5A5);
        wait_done("B");
        check("B_bad", 64'(bad), 64'd1);
        check("B_err", 64'(err_cnt), 64'd2);
        check("B_first_bad", 64'(first_bad), 64'd9);
        check("B_nrd", 64'(n_rd), 64'd16);
        corrupt_en = 1'b0;

        // all-zero read data saturates the narrow counter
        zero_data = 1'b1;
        start_run(1'b0, 16'hFFFF);
        wait_done("C");
        check("C_err_sat", 64'(err_cnt), 64'd3);
        check("C_first_bad", 64'(first_bad), 64'd0);
        check("C_bad", 64'(bad), 64'd1);
        check("C_nrd", 64'(n_rd), 64'd16);
        check("C_nwr", 64'(n_wr), 64'd0);
        zero_data = 1'b0;

        // LVBL low for 50 cycles after rdy of addr 5
        start_run(1'b0, 16'hA5A5);
        n = 0;
        while (!(bus.rdy && bus.addr == 4'd5) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("D_rdy5_seen", 64'(bus.rdy && bus.addr == 4'd5), 64'd1);
        LVBL = 1'b0;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.rd || bus.wr) viol++;
        end
        check("D_quiet", 64'(viol), 64'd0);
        LVBL = 1'b1;
        @(negedge clk);
        #1;
        check("D_rd_resume", 64'(bus.rd), 64'd1);
        check("D_addr_resume", 64'(bus.addr), 64'd6);
        wait_done("D");
        check("D_bad", 64'(bad), 64'd0);
        check("D_nrd", 64'(n_rd), 64'd16);

        // restart mid-read at addr 7 after an error at addr 2
        corrupt_en = 1'b1;
        c1 = 4'd2;
        c2 = 4'd2;
        start_run(1'b0, 16'hA5A5);
        n = 0;
        while (!(ph == 1 && cap_a == 4'd7) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("E_at7", 64'(ph == 1 && cap_a == 4'd7), 64'd1);
        check("E_err_before", 64'(err_cnt), 64'd1);
        corrupt_en = 1'b0;
        start_run(1'b0, 16'hA5A5);
        check("E_addr0", 64'(bus.addr), 64'd0);
        check("E_err0", 64'(err_cnt), 64'd0);
        check("E_flags", 64'({busy, bad, done}), 64'b100);
        wait_done("E");
        check("E_bad", 64'(bad), 64'd0);
        check("E_nrd", 64'(n_rd), 64'd16);
        check("E_nwr", 64'(n_wr), 64'd0);

        // ack and rdy together on every transfer
        combined = 1'b1;
        start_run(1'b1, 16'h1234);
        wait_done("F");
        check("F_bad", 64'(bad), 64'd0);
        check("F_nwr", 64'(n_wr), 64'd16);
        check("F_nrd", 64'(n_rd), 64'd16);

        // reset in the middle of a run with an error already logged
        corrupt_en = 1'b1;
        c1 = 4'd1;
        c2 = 4'd1;
        start_run(1'b1, 16'h0F0F);
        repeat (25) @(negedge clk);
        #1;
        check("G_bad_before", 64'(bad), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("G_req", 64'({bus.rd, bus.wr}), 64'd0);
        check("G_addr", 64'(bus.addr), 64'd0);
        check("G_din", 64'(bus.din), 64'd0);
        check("G_flags", 64'({busy, bad, done}), 64'd0);
        check("G_err", 64'(err_cnt), 64'd0);
        check("G_first_bad", 64'(first_bad), 64'd0);
        rst        = 1'b0;
        combined   = 1'b0;
        corrupt_en = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check("G_idle_req", 64'({bus.rd, bus.wr}), 64'd0);
        check("G_idle_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
